// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
// Round-robin arbitration is selected with macro TICK_SCHED_RR_EN (see tick_rr_arbiter).
package tick_sched_pkg;

  localparam int unsigned DEFAULT_DIV = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } sched_state_e;

endpackage

// File: rtl/tick_rr_arbiter.sv
// Picks one requester to own the tick being issued.
// TICK_SCHED_RR_EN defined: round-robin from a pointer; undefined: fixed priority, lowest index wins.
module tick_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            tick,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] sel;

`ifdef TICK_SCHED_RR_EN
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic            found;
  logic [PtrW-1:0] idx;

  // Search starts at the pointer and wraps; the pointer then moves past the winner.
  always_comb begin
    sel   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        sel[idx] = 1'b1;
        ptr_d    = (idx == PtrW'(NREQ - 1)) ? '0 : idx + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (tick && found) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset};

  // Isolate the lowest set bit.
  assign sel = req & (~req + NREQ'(1));
`endif

  assign grant = tick ? sel : '0;

endmodule

// File: rtl/tick_scheduler.sv
// Programmable tick divider with glitch-free ratio changes and per-tick requester grant.
// Arbitration policy selected by macro TICK_SCHED_RR_EN inside tick_rr_arbiter.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic [NREQ-1:0]  req,
  output logic             tick,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  sched_state_e     state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             tick_q;
  logic [NREQ-1:0]  grant_q;
  logic             busy_q;
  logic             cfg_ready_q;
  logic             cfg_err_q;

  logic             wrap;
  logic             cfg_accept;
  logic             cfg_zero;
  logic             cfg_take;
  logic             tick_next;
  logic [NREQ-1:0]  arb_grant;

  assign wrap       = (cnt_q == ratio_q - DIV_W'(1));
  assign cfg_accept = cfg_valid & cfg_ready_q;
  assign cfg_zero   = (cfg_div == '0);
  assign cfg_take   = cfg_accept & ~cfg_zero;
  // A disabling edge never produces a tick, even at the wrap point.
  assign tick_next  = (state_q != StIdle) & enable & wrap;

  tick_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .tick (tick_next),
    .grant(arb_grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cfg_take) ratio_d = cfg_div;
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (cfg_take) ratio_d = cfg_div;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
          if (cfg_take) begin
            // At the wrap the new period starts now, so the ratio can load directly.
            if (wrap) begin
              ratio_d = cfg_div;
            end else begin
              pend_d  = cfg_div;
              state_d = StPend;
            end
          end
        end
      end
      StPend: begin
        if (!enable) begin
          state_d = StIdle;
          cnt_d   = '0;
          ratio_d = pend_q;
          pend_d  = '0;
        end else if (wrap) begin
          state_d = StRun;
          cnt_d   = '0;
          ratio_d = pend_q;
          pend_d  = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ratio_q     <= DIV_W'(DEFAULT_DIV);
      pend_q      <= '0;
      tick_q      <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      pend_q      <= pend_d;
      tick_q      <= tick_next;
      grant_q     <= arb_grant;
      busy_q      <= (state_d != StIdle);
      cfg_ready_q <= (state_d != StPend);
      cfg_err_q   <= cfg_accept & cfg_zero;
    end
  end

  assign tick      = tick_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed literal checks plus a randomized run
// compared every cycle against a deadline-based behavioural model.
module tb_tick_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DIV_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [NREQ-1:0]  req = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic [NREQ-1:0]  grant;
  logic             busy;

  tick_scheduler #(
    .NREQ (NREQ),
    .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .req      (req),
    .tick     (tick),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ntick = 0;
  bit chk_on = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkg(input string nm, input logic [NREQ-1:0] act, input logic [NREQ-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the absolute cycle of the next tick rather than a phase counter.
  bit              m_run;
  int              m_r;
  int              m_pend;
  int              m_deadline;
  int              m_cyc;
  int              m_ptr;
  bit              m_tick;
  bit              m_busy;
  bit              m_ready;
  bit              m_err;
  logic [NREQ-1:0] m_grant;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef TICK_SCHED_RR_EN
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic m_reset();
    m_run = 0; m_r = 3; m_pend = 0; m_deadline = 0; m_cyc = 0; m_ptr = 0;
    m_tick = 0; m_busy = 0; m_ready = 1; m_err = 0; m_grant = '0;
  endtask

  task automatic m_step();
    int  nxt;
    int  w;
    bit  acc;
    bit  take;
    bit  t;
    nxt  = m_cyc + 1;
    acc  = cfg_valid && m_ready;
    take = acc && (cfg_div != 0);
    t    = 0;
    m_err = acc && (cfg_div == 0);
    if (!m_run) begin
      if (take) m_r = int'(cfg_div);
      if (enable) begin
        m_run = 1;
        m_deadline = nxt + m_r;
      end
    end else if (!enable) begin
      m_run = 0;
      if (take) m_r = int'(cfg_div);
      else if (m_pend != 0) m_r = m_pend;
      m_pend = 0;
    end else begin
      t = (nxt == m_deadline);
      if (t) begin
        if (m_pend != 0) begin
          m_r = m_pend;
          m_pend = 0;
        end
        if (take) m_r = int'(cfg_div);
        m_deadline = nxt + m_r;
      end else if (take) begin
        m_pend = int'(cfg_div);
      end
    end
    m_tick  = t;
    m_grant = '0;
    if (t) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_grant[w] = 1'b1;
        m_ptr = (w + 1) % NREQ;
      end
    end
    m_busy  = m_run;
    m_ready = !(m_run && m_pend != 0);
    m_cyc   = nxt;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk1("m_tick", tick, m_tick);
      chkg("m_grant", grant, m_grant);
      chk1("m_busy", busy, m_busy);
      chk1("m_ready", cfg_ready, m_ready);
      chk1("m_err", cfg_err, m_err);
    end
  end

  // ---------------- directed literal expectations ----------------
  // Grant sequence for req=1011 held steady, counted from a fresh reset.
  function automatic logic [NREQ-1:0] gexp(input int n);
`ifdef TICK_SCHED_RR_EN
    case (n % 3)
      0:       return 4'b0001;
      1:       return 4'b0010;
      default: return 4'b1000;
    endcase
`else
    return 4'b0001;
`endif
  endfunction

  task automatic tk(input string nm, input bit exp_t);
    chk1(nm, tick, exp_t);
    if (exp_t) begin
      chkg({nm, "_grant"}, grant, gexp(ntick));
      ntick++;
    end else begin
      chkg({nm, "_grant"}, grant, '0);
    end
  endtask

  initial begin
    req = 4'b1011;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk1("rst_tick", tick, 1'b0);
    chkg("rst_grant", grant, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", cfg_ready, 1'b1);
    chk1("rst_err", cfg_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // R=3: ticks at RUN cycles 3, 6, 9
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      tk("r3_tick", (k > 0) && (k % 3 == 0));
      chk1("r3_busy", busy, 1'b1);
    end

    // Zero ratio rejected; spacing stays 3
    cfg_valid = 1'b1;
    cfg_div   = 4'd0;
    for (int k = 10; k <= 15; k++) begin
      @(negedge clk);
      if (k == 10) cfg_valid = 1'b0;
      chk1("zero_err", cfg_err, k == 10);
      tk("zero_tick", (k == 12) || (k == 15));
    end

    // R=5 offered mid-period: old period completes at 18, then 23, 28
    cfg_valid = 1'b1;
    cfg_div   = 4'd5;
    for (int k = 16; k <= 28; k++) begin
      @(negedge clk);
      if (k == 16) cfg_valid = 1'b0;
      chk1("r5_ready", cfg_ready, k >= 18);
      tk("r5_tick", (k == 18) || (k == 23) || (k == 28));
    end

    // Drop enable while loading R=1 from RUN
    enable    = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = 4'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    tk("dis_tick", 1'b0);
    chk1("dis_busy", busy, 1'b0);
    chk1("dis_ready", cfg_ready, 1'b1);
    enable = 1'b1;
    for (int k = 30; k <= 35; k++) begin
      @(negedge clk);
      tk("r1_tick", k >= 31);
      chk1("r1_busy", busy, 1'b1);
    end
    enable = 1'b0;
    @(negedge clk);
    tk("r1_off_tick", 1'b0);
    chk1("r1_off_busy", busy, 1'b0);

    // Reset at counter=1 abandons the period; R returns to 3
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("mid_rst_tick", tick, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chkg("mid_rst_grant", grant, '0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    ntick = 0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      tk("post_rst_tick", (k == 3) || (k == 6));
      chk1("post_rst_ready", cfg_ready, 1'b1);
    end

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 24) != 0);
      cfg_valid = ($urandom_range(0, 6) == 0);
      cfg_div   = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 15))
                                              : DIV_W'($urandom_range(0, 4));
      req       = NREQ'($urandom);
      if ($urandom_range(0, 400) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the tick (2..8).
REQ-002 Parameter DIV_W, default 4: width of the divide ratio.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  1 = divider runs; 0 = divider halts.
REQ-006 cfg_valid  input  1  new divide ratio offered.
REQ-007 cfg_div  input  DIV_W  requested ratio R; legal range 1..2^DIV_W-1.
REQ-008 cfg_ready  output  1  scheduler can accept a ratio this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse: offered ratio rejected.
REQ-010 req  input  NREQ  per-requester tick request, level.
REQ-011 tick  output  1  one-cycle pulse every R cycles while running.
REQ-012 grant  output  NREQ  one-hot owner of the current tick, else zero.
REQ-013 busy  output  1  high in RUN and PEND states.

Function
REQ-014 Control FSM SHALL have states IDLE, RUN and PEND; all outputs are registered.
REQ-015 IDLE: period counter held at 0; tick and grant are 0; enable=1 moves to RUN on the next edge.
REQ-016 RUN: the counter counts 0..R-1 and wraps; tick=1 in the cycle after the counter equals R-1. The first tick occurs R cycles after the first RUN cycle.
REQ-017 When R=1, tick SHALL stay high every cycle in RUN.
REQ-018 cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND; a ratio is accepted when cfg_valid and cfg_ready are both high.
REQ-019 Accepted cfg_div=0 SHALL be rejected: cfg_err pulses for one cycle, the ratio is unchanged and the state is unchanged.
REQ-020 A legal ratio accepted in IDLE SHALL take effect on the next edge.
REQ-021 A legal ratio accepted in RUN SHALL be stored and the FSM moves to PEND.
REQ-022 PEND: the old ratio finishes the current period. At the wrap point the new ratio loads, the counter clears and the FSM returns to RUN, so no period is ever truncated.
REQ-023 enable=0 in RUN or PEND SHALL move to IDLE on the next edge, with the counter cleared and no tick. A pending ratio is applied on that edge.
REQ-024 On each tick with req nonzero, grant SHALL select exactly one requesting index in the same cycle as tick; with req=0, grant=0 and tick still pulses.
REQ-025 Simultaneous cfg acceptance and tick in RUN: the tick is issued normally and the new ratio governs from the following period.

Reset
REQ-026 Reset SHALL force IDLE, counter=0, R=3, pending ratio cleared, tick=0, grant=0, cfg_err=0, busy=0, cfg_ready=1 and arbitration pointer=0.
REQ-027 Reset asserted mid-period SHALL abandon the period and any pending ratio immediately, with no tick emitted.

Configuration
REQ-028 With macro TICK_SCHED_RR_EN defined, arbitration SHALL be round-robin. The search starts at the pointer, and the pointer moves to granted index+1 (mod NREQ) after each grant; it is unchanged when grant=0.
REQ-029 Without TICK_SCHED_RR_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register exists.

Structure
REQ-030 Package tick_sched_pkg SHALL hold the FSM state enum typedef and the constant DEFAULT_DIV=3.
REQ-031 Arbitration SHALL live in sub-module tick_rr_arbiter (NREQ parameter; req, tick in; grant out). The TICK_SCHED_RR_EN switch is contained there.

Verification
REQ-032 Reset, enable=1, R=3 -> tick high on cycles 3, 6, 9 after entering RUN; busy=1.
REQ-033 Cfg R=5 offered mid-period while running at R=3 -> cfg_ready=0 until the wrap; the current 3-cycle period completes, then ticks are spaced 5 apart.
REQ-034 cfg_div=0 offered in RUN -> cfg_err pulses once; tick spacing remains 3.
REQ-035 TICK_SCHED_RR_EN defined, req=4'b1011 steady -> grants 0001, 0010, 1000, 0001 on successive ticks. Macro undefined -> 0001 on every tick.
REQ-036 R=1 -> tick continuously high. enable dropped -> tick=0 next cycle, state IDLE, counter 0.
REQ-037 Reset asserted at counter=1 -> no tick; after release, all outputs at their reset values and R=3.
